// File: rtl/mul_issue_ctrl.sv
// ----------------------------------------------------------------------------
// mul_issue_ctrl : credit-limited issue/result wrapper for the pipelined multiplier
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mul_issue_ctrl #(
  parameter int MUL_LAT   = 3,
  parameter int RES_DEPTH = 4,
  parameter int TAG_W     = 5
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              flush_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [31:0]       req_rs1_i,
  input  logic [31:0]       req_rs2_i,
  input  logic [TAG_W-1:0]  req_rd_i,
  output logic [31:0]       mul_rs1_o,
  output logic [31:0]       mul_rs2_o,
  input  logic [31:0]       mul_res_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [31:0]       res_data_o,
  output logic [TAG_W-1:0]  res_rd_o,
  output logic              busy_o
);

  localparam int PTR_W = $clog2(RES_DEPTH);
  localparam int OCC_W = $clog2(RES_DEPTH + 1);
  localparam int SUM_W = $clog2(RES_DEPTH + MUL_LAT + 1);
  localparam int ENT_W = 32 + TAG_W;

  logic                 accept;
  logic [MUL_LAT-1:0]   tag_vld;
  logic [TAG_W-1:0]     tag_rd [MUL_LAT];
  logic [SUM_W-1:0]     inflight;
  logic [SUM_W-1:0]     used;
  logic [ENT_W-1:0]     mem [RES_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [OCC_W-1:0]     occ;
  logic                 push;
  logic                 pop;
  logic [ENT_W-1:0]     head;

  assign accept    = req_valid_i & req_ready_o;
  assign mul_rs1_o = accept ? req_rs1_i : '0;
  assign mul_rs2_o = accept ? req_rs2_i : '0;

  // Entry MUL_LAT-1 lines up with the product currently on mul_res_i.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tag_vld <= '0;
      for (int k = 0; k < MUL_LAT; k++) tag_rd[k] <= '0;
    end else if (flush_i) begin
      tag_vld <= '0;
    end else begin
      tag_vld[0] <= accept;
      tag_rd[0]  <= req_rd_i;
      for (int k = 1; k < MUL_LAT; k++) begin
        tag_vld[k] <= tag_vld[k-1];
        tag_rd[k]  <= tag_rd[k-1];
      end
    end
  end

  always_comb begin
    inflight = '0;
    for (int k = 0; k < MUL_LAT; k++) inflight = inflight + SUM_W'(tag_vld[k]);
  end

  // Every accepted op owns a FIFO slot until popped, so a push never finds it full.
  assign used        = inflight + SUM_W'(occ);
  assign req_ready_o = ~flush_i & (used < SUM_W'(RES_DEPTH));
  assign busy_o      = (inflight != '0) | (occ != '0);

  assign push = tag_vld[MUL_LAT-1];
  assign pop  = res_valid_o & res_ready_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int k = 0; k < RES_DEPTH; k++) mem[k] <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {mul_res_i, tag_rd[MUL_LAT-1]};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  assign head        = mem[rd_ptr];
  assign res_valid_o = (occ != '0);
  assign res_data_o  = res_valid_o ? head[ENT_W-1:TAG_W] : '0;
  assign res_rd_o    = res_valid_o ? head[TAG_W-1:0]     : '0;

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (rstn_i && !flush_i)
      assert (!(push && occ == OCC_W'(RES_DEPTH)))
        else $error("push into full result FIFO");
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mul_issue_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mul_issue_ctrl : scoreboard bench for mul_issue_ctrl with a 3-stage multiplier model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mul_issue_ctrl;

  localparam int MUL_LAT   = 3;
  localparam int RES_DEPTH = 4;
  localparam int TAG_W     = 5;

  logic              clk_i = 1'b0;
  logic              rstn_i;
  logic              flush_i;
  logic              req_valid_i;
  logic              req_ready_o;
  logic [31:0]       req_rs1_i;
  logic [31:0]       req_rs2_i;
  logic [TAG_W-1:0]  req_rd_i;
  logic [31:0]       mul_rs1_o;
  logic [31:0]       mul_rs2_o;
  logic [31:0]       mul_res_i;
  logic              res_valid_o;
  logic              res_ready_i;
  logic [31:0]       res_data_o;
  logic [TAG_W-1:0]  res_rd_o;
  logic              busy_o;

  mul_issue_ctrl #(.MUL_LAT(MUL_LAT), .RES_DEPTH(RES_DEPTH), .TAG_W(TAG_W)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i), .req_rd_i(req_rd_i),
    .mul_rs1_o(mul_rs1_o), .mul_rs2_o(mul_rs2_o), .mul_res_i(mul_res_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_data_o(res_data_o), .res_rd_o(res_rd_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Multiplier model: cannot stall, shares the reset, ignores flush.
  logic [31:0] mpipe [MUL_LAT];
  always @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int k = 0; k < MUL_LAT; k++) mpipe[k] <= '0;
    end else begin
      mpipe[0] <= mul_rs1_o * mul_rs2_o;
      for (int k = 1; k < MUL_LAT; k++) mpipe[k] <= mpipe[k-1];
    end
  end
  assign mul_res_i = mpipe[MUL_LAT-1];

  logic [32+TAG_W-1:0] exp_q [$];
  int vectors    = 0;
  int miscompares = 0;
  int delivered  = 0;

  // Scoreboard: accepts push the expected product, writeback pops compare it.
  always @(negedge clk_i) begin
    if (!rstn_i) begin
      exp_q.delete();
    end else begin
      if (res_valid_o) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL spurious_result: got data=%h rd=%0d, expected no result", res_data_o, res_rd_o);
        end else if ({res_data_o, res_rd_o} !== exp_q[0]) begin
          miscompares++;
          $display("FAIL result: got data=%h rd=%0d, expected data=%h rd=%0d",
                   res_data_o, res_rd_o, exp_q[0][32+TAG_W-1:TAG_W], exp_q[0][TAG_W-1:0]);
        end
        if (res_ready_i && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          delivered++;
        end
      end
      if (flush_i) exp_q.delete();
      if (req_valid_i && req_ready_o) begin
        vectors++;
        if (mul_rs1_o !== req_rs1_i || mul_rs2_o !== req_rs2_i) begin
          miscompares++;
          $display("FAIL operand_drive: got %h,%h expected %h,%h", mul_rs1_o, mul_rs2_o, req_rs1_i, req_rs2_i);
        end
        exp_q.push_back({32'(req_rs1_i * req_rs2_i), req_rd_i});
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_req(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
    req_valid_i = v;
    req_rs1_i   = a;
    req_rs2_i   = b;
    req_rd_i    = t;
  endtask

  task automatic test_reset();
    rstn_i = 1'b0; flush_i = 1'b0; res_ready_i = 1'b0;
    drive_req(1'b0, '0, '0, '0);
    step(); step();
    vectors++;
    if ({res_valid_o, busy_o, req_ready_o} !== 3'b001) begin
      miscompares++;
      $display("FAIL reset_flags: got valid/busy/ready=%b expected 001", {res_valid_o, busy_o, req_ready_o});
    end
    vectors++;
    if ({res_data_o, res_rd_o, mul_rs1_o, mul_rs2_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got data=%h rd=%0d rs1=%h rs2=%h expected all 0", res_data_o, res_rd_o, mul_rs1_o, mul_rs2_o);
    end
    #3 rstn_i = 1'b1;
    step();
  endtask

  task automatic test_single();
    res_ready_i = 1'b1;
    drive_req(1'b1, 32'd6, 32'd7, 5'd3);
    #1;
    vectors++;
    if (req_ready_o !== 1'b1 || mul_rs1_o !== 32'd6 || mul_rs2_o !== 32'd7) begin
      miscompares++;
      $display("FAIL single_issue: got ready=%b rs1=%h rs2=%h expected 1,6,7", req_ready_o, mul_rs1_o, mul_rs2_o);
    end
    step();
    drive_req(1'b0, '0, '0, '0);
    for (int c = 1; c <= 5; c++) begin
      #1;
      vectors++;
      if (res_valid_o !== (c == 4) || busy_o !== (c <= 4)) begin
        miscompares++;
        $display("FAIL single_latency: cycle T+%0d got valid=%b busy=%b expected %b,%b",
                 c, res_valid_o, busy_o, (c == 4), (c <= 4));
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [4];
    logic [31:0] b [4];
    a[0] = 32'd2;          b[0] = 32'd3;
    a[1] = 32'd4;          b[1] = 32'd5;
    a[2] = 32'hFFFF_FFFF;  b[2] = 32'd2;
    a[3] = 32'h0001_0000;  b[3] = 32'h0001_0000;
    res_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_req(1'b1, a[i], b[i], 5'(i + 1));
      #1;
      vectors++;
      if (req_ready_o !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_ready: op %0d got ready=%b expected 1", i, req_ready_o);
      end
      step();
    end
    drive_req(1'b0, '0, '0, '0);
    for (int c = 4; c <= 8; c++) begin
      #1;
      vectors++;
      if (res_valid_o !== (c <= 7)) begin
        miscompares++;
        $display("FAIL b2b_stream: cycle T+%0d got valid=%b expected %b", c, res_valid_o, (c <= 7));
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    int d0;
    d0 = delivered;
    res_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive_req(1'b1, 32'(n + 11), 32'(n + 100), 5'(n + 8));
      #1;
      vectors++;
      if (req_ready_o !== (i < 4)) begin
        miscompares++;
        $display("FAIL bp_ready: offer %0d got ready=%b expected %b", i, req_ready_o, (i < 4));
      end
      if (req_ready_o) n++;
      step();
    end
    drive_req(1'b0, '0, '0, '0);
    vectors++;
    if (n != 4) begin
      miscompares++;
      $display("FAIL bp_accepted: got %0d accepted expected 4", n);
    end
    step(); step(); step();
    res_ready_i = 1'b1;
    #1;
    vectors++;
    if (res_valid_o !== 1'b1 || req_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_pop_cycle: got valid=%b ready=%b expected 1,0", res_valid_o, req_ready_o);
    end
    step();
    vectors++;
    if (req_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_reopen: got ready=%b expected 1", req_ready_o);
    end
    for (int c = 0; c < 20 && (exp_q.size() != 0 || res_valid_o); c++) step();
    vectors++;
    if (delivered - d0 != 4) begin
      miscompares++;
      $display("FAIL bp_drain: got %0d results expected 4", delivered - d0);
    end
  endtask

  task automatic test_flush();
    int d0;
    res_ready_i = 1'b0;
    drive_req(1'b1, 32'd5, 32'd5, 5'd10); step();
    drive_req(1'b0, '0, '0, '0);          step();
    drive_req(1'b1, 32'd6, 32'd6, 5'd11); step();
    drive_req(1'b1, 32'd7, 32'd7, 5'd12); step();
    drive_req(1'b0, '0, '0, '0);
    flush_i = 1'b1;
    #1;
    vectors++;
    if (req_ready_o !== 1'b0 || busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_cycle: got ready=%b busy=%b expected 0,1", req_ready_o, busy_o);
    end
    step();
    flush_i = 1'b0;
    d0 = delivered;
    vectors++;
    if (res_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_clear: got valid=%b busy=%b expected 0,0", res_valid_o, busy_o);
    end
    res_ready_i = 1'b1;
    drive_req(1'b1, 32'd3, 32'd3, 5'd13);
    step();
    drive_req(1'b0, '0, '0, '0);
    for (int c = 0; c < 10; c++) step();
    vectors++;
    if (delivered - d0 != 1 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL flush_after: got %0d results, %0d pending, expected 1,0", delivered - d0, exp_q.size());
    end
  endtask

  task automatic test_reset_midop();
    res_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_req(1'b1, 32'(i + 20), 32'(i + 30), 5'(i + 20));
      step();
    end
    drive_req(1'b0, '0, '0, '0);
    rstn_i = 1'b0;
    #1;
    vectors++;
    if ({res_valid_o, busy_o, req_ready_o, res_data_o, res_rd_o, mul_rs1_o, mul_rs2_o} !== {3'b001, {(96+TAG_W){1'b0}}}) begin
      miscompares++;
      $display("FAIL reset_midop: got valid=%b busy=%b ready=%b data=%h rd=%0d expected reset values",
               res_valid_o, busy_o, req_ready_o, res_data_o, res_rd_o);
    end
    step(); step();
    #3 rstn_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      vectors++;
      if (res_valid_o !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_stale: cycle %0d got valid=%b expected 0", c, res_valid_o);
      end
    end
  endtask

  task automatic test_wrap();
    int n = 0;
    int cyc = 0;
    int d0;
    d0 = delivered;
    while (n < 20 && cyc < 400) begin
      res_ready_i = (cyc % 2 == 0);
      drive_req(1'b1, 32'(n * 1234567 + 11), 32'(n * 7 + 3), 5'(n));
      #1;
      if (req_ready_o) n++;
      step();
      cyc++;
    end
    drive_req(1'b0, '0, '0, '0);
    for (int c = 0; c < 200 && (exp_q.size() != 0 || res_valid_o); c++) begin
      res_ready_i = (c % 2 == 0);
      step();
    end
    res_ready_i = 1'b1;
    vectors++;
    if (n != 20) begin
      miscompares++;
      $display("FAIL wrap_issue: got %0d accepted expected 20 (budget expired)", n);
    end
    vectors++;
    if (delivered - d0 != 20 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL wrap_deliver: got %0d results, %0d pending, expected 20,0", delivered - d0, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_midop();
    test_wrap();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/mul_issue_ctrl.md
Name: mul_issue_ctrl

Overview:
Control and buffering wrapper placed directly upstream of the 3-stage pipelined multiplier in the exe stage.
- Accepts multiply requests from issue with a valid/ready handshake and drives operands into the multiplier.
- Carries each request's destination-register tag through a shift pipe whose depth matches the multiplier latency.
- Captures each product into a small result FIFO. Writeback drains the FIFO through its own valid/ready handshake.
- Admission is credit-limited, so no product is ever lost even though the multiplier itself cannot stall.

Parameters:
- MUL_LAT, 3, multiplier latency in cycles; operands at cycle T give a product on mul_res_i during cycle T+MUL_LAT.
- RES_DEPTH, 4, result FIFO entries; must be a power of 2 and at least 2.
- TAG_W, 5, destination register index width.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- flush_i  in  1  kill all in-flight and buffered operations
- req_valid_i  in  1  multiply request valid
- req_ready_o  out  1  controller can accept a request
- req_rs1_i  in  32  operand A
- req_rs2_i  in  32  operand B
- req_rd_i  in  TAG_W  destination register tag
- mul_rs1_o  out  32  operand A to multiplier
- mul_rs2_o  out  32  operand B to multiplier
- mul_res_i  in  32  multiplier product
- res_valid_o  out  1  result available for writeback
- res_ready_i  in  1  writeback consumes result
- res_data_o  out  32  result value
- res_rd_o  out  TAG_W  result destination tag
- busy_o  out  1  any operation in flight or buffered

Behaviour:
- Clocking and reset: clk_i is the clock. rstn_i is asynchronous, active-low; every flop uses it. The multiplier shares the same reset.
- Reset values: tag pipe valids 0, FIFO pointers 0, counters 0. res_valid_o=0, res_data_o=0, res_rd_o=0, busy_o=0, mul_rs1_o=0, mul_rs2_o=0, req_ready_o=1.
- Accept condition: accept = req_valid_i & req_ready_o.
- Operand drive: mul_rs1_o/mul_rs2_o = req_rs1/2_i when accept, else 0. This is combinational, with no register stage.
- Tag pipe:
  - MUL_LAT entries of {valid, rd}.
  - Entry 0 loads {accept, req_rd_i} each cycle; entry k loads entry k-1.
  - Entry MUL_LAT-1 is time-aligned with mul_res_i.
- FIFO push: when entry MUL_LAT-1 is valid, push {mul_res_i, rd} into the FIFO on that edge.
- Latency: a request accepted in cycle T gives res_valid_o=1 in cycle T+MUL_LAT+1 (T+4 at default). The FIFO has no bypass.
- Throughput: 1 op/cycle sustained while writeback keeps up.
- FIFO output:
  - res_valid_o = FIFO not empty.
  - res_data_o/res_rd_o show the head entry; they are 0 when empty.
  - Pop on res_valid_o & res_ready_i. res_ready_i while empty is ignored.
- Credits:
  - inflight = count of valid tag entries; occ = FIFO occupancy.
  - req_ready_o = ~flush_i & (inflight + occ < RES_DEPTH).
  - req_ready_o must not depend combinationally on res_ready_i or req_valid_i.
- Full FIFO with pop: when occ + inflight == RES_DEPTH, req_ready_o=0 even in a cycle with a pop. It reopens the next cycle.
- Simultaneous push and pop: allowed in the same cycle; occupancy is unchanged. A push into a full FIFO is impossible by credit construction. Add a simulation assertion for it.
- Pointer wrap: pointers wrap modulo RES_DEPTH. Use a separate occupancy counter (or an extra pointer bit) to tell full from empty.
- Flush:
  - flush_i=1 in cycle F: all tag valids and the FIFO clear at the F edge; res_valid_o=0 from F+1.
  - No request is accepted in cycle F.
  - Products already in the multiplier still arrive but have no valid tag, so they are discarded.
  - Requests accepted from F+1 onward are unaffected.
- Reset mid-operation: everything clears immediately and asynchronously. No stale result appears after reset release.
- rd=0: treated as a normal op and still produced; filtering is writeback's job.
- busy_o = (inflight != 0) | (occ != 0), registered-equivalent from state only.

Test Plan:
- Single op: rs1=6, rs2=7, rd=3 accepted at T, res_ready_i=1 -> res_valid_o only at T+4, data=42, rd=3, one cycle; busy_o falls at T+5.
- Back-to-back: 4 ops (2x3, 4x5, 0xFFFFFFFFx2, 0x10000x0x10000) on consecutive cycles, ready=1 -> results 6, 20, 0xFFFFFFFE, 0 on consecutive cycles in order, rd tags matching.
- Backpressure: res_ready_i=0, 6 requests offered -> only 4 accepted and req_ready_o=0 thereafter. Then res_ready_i=1 -> 4 results in order; req_ready_o returns 1 the cycle after the first pop.
- Flush mid-flight: 2 ops in tag pipe and 1 in FIFO, flush_i pulsed -> no results ever appear for them; a new op 3x3 issued at F+1 returns 9.
- Reset mid-op: rstn_i asserted with 3 ops in flight -> all outputs at reset values immediately; after release, no spurious res_valid_o over 10 cycles.
- Wrap and simultaneous push/pop: 20 ops streamed with res_ready_i toggling 1,0,1,0 -> all 20 products delivered in order with no loss or duplication, and the push-into-full assertion never fires.
